// File: rtl/fft_frame_sink.sv
// fft_frame_sink
//   Receives the FFT output stream (valid/sop/re/im), captures whole frames
//   into a two-bank ping-pong RAM, flags short and dropped frames, and replays
//   each completed frame on a valid/ready output port.
//   Frame length is 64 << np (64/128/256/512).
//
//   Optional build macro:
//     FRAME_SINK_BITREV_EN - replay reads address bitrev(out_idx) over
//                            log2(len) bits, turning bit-reversed FFT output
//                            into natural order. Undefined: natural replay.
//
//   Output handshake: out_valid/out_sop/out_eop/out_idx/out_re/out_im are
//   registered; once out_valid is high they hold steady until a cycle where
//   out_ready is also high, and that cycle is the transfer. The input side
//   has no backpressure: every valid_in beat is taken or deliberately ignored.
//
//   wr_state_dbg exposes the write FSM state (0 idle, 1 capture, 2 skip).
module fft_frame_sink #(
  parameter int DW      = 16,
  parameter int NMAX_LG = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         np,
  input  logic               valid_in,
  input  logic               sop_in,
  input  logic [DW-1:0]      x_re,
  input  logic [DW-1:0]      x_im,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic [DW-1:0]      out_re,
  output logic [DW-1:0]      out_im,
  output logic [NMAX_LG-1:0] out_idx,
  output logic               err_short,
  output logic               drop,
  output logic [1:0]         wr_state_dbg
);

  localparam int CW = NMAX_LG + 1;   // frame counters
  localparam int AW = NMAX_LG;       // address within one bank
  localparam int WW = 2 * DW;        // stored complex word

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_CAP  = 2'd1,
    W_SKIP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    B_EMPTY = 2'd0,
    B_FULL  = 2'd1,
    B_DRAIN = 2'd2
  } b_state_t;

  function automatic logic [CW-1:0] frame_len(input logic [1:0] n);
    return CW'(64) << n;
  endfunction

`ifdef FRAME_SINK_BITREV_EN
  // Reverse idx over log2(64 << n) bits: reverse all AW bits, then shift the
  // result down so only the low log2(len) bits remain.
  function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] idx,
                                            input logic [1:0]    n);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[AW-1-i] = idx[i];
    return r >> (AW - 6 - int'(n));
  endfunction
`endif

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  w_state_t      w_state;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [CW-1:0] wr_cnt;
  b_state_t      bank_st [2];
  logic [1:0]    bank_np [2];

  logic [WW-1:0] mem [2 * (2 ** AW)];

  // Read issue side: walks a FULL bank and launches one RAM read per cycle
  // while the output buffer has room. iss_ptr runs ahead of rd_ptr, which
  // only advances when the frame's last sample leaves the output port.
  logic          iss_ptr;
  logic          iss_active;
  logic [CW-1:0] iss_cnt;
  logic [1:0]    iss_np;

  // RAM read register and the metadata travelling alongside it
  logic          rv;
  logic [WW-1:0] rdat;
  logic [AW-1:0] r_idx;
  logic          r_sop;
  logic          r_eop;

  // 2-entry output buffer, slot 0 is the head presented on out_*
  logic [1:0]    f_vld;
  logic [WW-1:0] f_dat [2];
  logic [AW-1:0] f_idx [2];
  logic          f_sop [2];
  logic          f_eop [2];

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic          sop_beat;
  logic          wr_free;
  logic          claim;
  logic          restart;
  logic          cap_beat;
  logic          cap_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  logic          iss_start;
  logic          iss_go;
  logic          iss_last;
  logic [CW-1:0] iss_cur;
  logic [1:0]    iss_np_cur;
  logic [AW-1:0] iss_addr;
  logic          pop;
  logic          eop_xfer;
  logic [2:0]    occ_next;
  logic          issue_ok;

  // Read issue decision and output-buffer credit
  always_comb begin
    pop        = f_vld[0] && out_ready;
    eop_xfer   = pop && f_eop[0];
    iss_start  = !iss_active && (bank_st[iss_ptr] == B_FULL);
    iss_np_cur = iss_active ? iss_np  : bank_np[iss_ptr];
    iss_cur    = iss_active ? iss_cnt : '0;
    iss_last   = (iss_cur == frame_len(iss_np_cur) - CW'(1));
    // Entries held after this edge: a read issued now lands one edge later,
    // so at most one may be buffered or in flight for it to fit.
    occ_next   = 3'(f_vld[0]) + 3'(f_vld[1]) + 3'(rv) - 3'(pop);
    issue_ok   = (occ_next <= 3'd1);
    iss_go     = (iss_active || iss_start) && issue_ok;
`ifdef FRAME_SINK_BITREV_EN
    iss_addr   = bit_rev(iss_cur[AW-1:0], iss_np_cur);
`else
    iss_addr   = iss_cur[AW-1:0];
`endif
  end

  // Write-side beat classification; a bank being released this cycle may be
  // claimed in the same cycle
  always_comb begin
    sop_beat = valid_in && sop_in;
    wr_free  = (bank_st[wr_ptr] == B_EMPTY) || (eop_xfer && (rd_ptr == wr_ptr));
    claim    = sop_beat && (w_state != W_CAP) && wr_free;
    restart  = sop_beat && (w_state == W_CAP);
    cap_beat = valid_in && !sop_in && (w_state == W_CAP);
    cap_done = cap_beat && (wr_cnt == frame_len(bank_np[wr_ptr]) - CW'(1));
    wr_en    = claim || restart || cap_beat;
    wr_addr  = (claim || restart) ? '0 : wr_cnt[AW-1:0];
  end

  // ---------------------------------------------------------------------
  // Write FSM: capture, short-frame restart, skip after a drop
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      wr_ptr    <= 1'b0;
      wr_cnt    <= '0;
      err_short <= 1'b0;
      drop      <= 1'b0;
    end else begin
      err_short <= 1'b0;
      drop      <= 1'b0;
      case (w_state)
        W_IDLE, W_SKIP: begin
          if (sop_beat) begin
            if (wr_free) begin
              w_state <= W_CAP;
              wr_cnt  <= CW'(1);
            end else begin
              drop    <= 1'b1;
              w_state <= W_SKIP;
            end
          end
        end
        W_CAP: begin
          if (restart) begin
            err_short <= 1'b1;
            wr_cnt    <= CW'(1);
          end else if (cap_beat) begin
            if (cap_done) begin
              w_state <= W_IDLE;
              wr_ptr  <= ~wr_ptr;
              wr_cnt  <= '0;
            end else begin
              wr_cnt <= wr_cnt + CW'(1);
            end
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign wr_state_dbg = w_state;

  // ---------------------------------------------------------------------
  // Bank bookkeeping: EMPTY -> (capture) -> FULL -> DRAINING -> EMPTY
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        bank_st[b] <= B_EMPTY;
        bank_np[b] <= '0;
      end
    end else begin
      if (eop_xfer) rd_ptr <= ~rd_ptr;
      for (int b = 0; b < 2; b++) begin
        if (cap_done && (wr_ptr == 1'(b)))
          bank_st[b] <= B_FULL;
        else if (iss_go && iss_start && (iss_ptr == 1'(b)))
          bank_st[b] <= B_DRAIN;
        else if (eop_xfer && (rd_ptr == 1'(b)))
          bank_st[b] <= B_EMPTY;
        if ((claim || restart) && (wr_ptr == 1'(b)))
          bank_np[b] <= np;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Ping-pong RAM: one write port (capture bank), one synchronous read port
  // (draining bank); the two never address the same bank at once
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_ptr, wr_addr}] <= {x_re, x_im};
    if (iss_go) rdat <= mem[{iss_ptr, iss_addr}];
  end

  // Read issue counter; moves straight on to the next FULL bank without a gap
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_active <= 1'b0;
      iss_cnt    <= '0;
      iss_np     <= '0;
      iss_ptr    <= 1'b0;
      rv         <= 1'b0;
      r_idx      <= '0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
    end else begin
      rv <= iss_go;
      if (iss_go) begin
        r_idx <= iss_cur[AW-1:0];
        r_sop <= (iss_cur == '0);
        r_eop <= iss_last;
        if (iss_last) begin
          iss_active <= 1'b0;
          iss_cnt    <= '0;
          iss_ptr    <= ~iss_ptr;
        end else begin
          iss_active <= 1'b1;
          iss_cnt    <= iss_cur + CW'(1);
          iss_np     <= iss_np_cur;
        end
      end
    end
  end

  // Two-entry output buffer: pop from slot 0, push read data into first free slot
  always_ff @(posedge clk) begin
    if (rst) begin
      f_vld <= 2'b00;
      for (int s = 0; s < 2; s++) begin
        f_dat[s] <= '0;
        f_idx[s] <= '0;
        f_sop[s] <= 1'b0;
        f_eop[s] <= 1'b0;
      end
    end else if (pop) begin
      if (f_vld[1]) begin
        f_dat[0] <= f_dat[1];
        f_idx[0] <= f_idx[1];
        f_sop[0] <= f_sop[1];
        f_eop[0] <= f_eop[1];
        if (rv) begin
          f_dat[1] <= rdat;
          f_idx[1] <= r_idx;
          f_sop[1] <= r_sop;
          f_eop[1] <= r_eop;
        end else begin
          f_vld[1] <= 1'b0;
        end
      end else if (rv) begin
        f_dat[0] <= rdat;
        f_idx[0] <= r_idx;
        f_sop[0] <= r_sop;
        f_eop[0] <= r_eop;
      end else begin
        f_vld[0] <= 1'b0;
      end
    end else if (rv) begin
      if (!f_vld[0]) begin
        f_vld[0] <= 1'b1;
        f_dat[0] <= rdat;
        f_idx[0] <= r_idx;
        f_sop[0] <= r_sop;
        f_eop[0] <= r_eop;
      end else begin
        f_vld[1] <= 1'b1;
        f_dat[1] <= rdat;
        f_idx[1] <= r_idx;
        f_sop[1] <= r_sop;
        f_eop[1] <= r_eop;
      end
    end
  end

  assign out_valid = f_vld[0];
  assign out_sop   = f_sop[0];
  assign out_eop   = f_eop[0];
  assign out_idx   = f_idx[0];
  assign out_re    = f_dat[0][WW-1:DW];
  assign out_im    = f_dat[0][DW-1:0];

endmodule

// File: tb/tb_fft_frame_sink.sv
// Testbench for fft_frame_sink: randomized frames checked through an
// expected-sample queue filled by a frame-level reference model.
module tb_fft_frame_sink;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int EW = 2 + AW + 2 * DW;   // {sop, eop, idx, re, im}

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    np = 2'd0;
  logic          valid_in = 1'b0;
  logic          sop_in = 1'b0;
  logic [DW-1:0] x_re = '0;
  logic [DW-1:0] x_im = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [AW-1:0] out_idx;
  logic          err_short;
  logic          drop;
  logic [1:0]    wr_state_dbg;

  always #5 clk = ~clk;

  fft_frame_sink #(.DW(DW), .NMAX_LG(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .np           (np),
    .valid_in     (valid_in),
    .sop_in       (sop_in),
    .x_re         (x_re),
    .x_im         (x_im),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_re       (out_re),
    .out_im       (out_im),
    .out_idx      (out_idx),
    .err_short    (err_short),
    .drop         (drop),
    .wr_state_dbg (wr_state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int              n_vec = 0;
  int              n_err = 0;
  logic [EW-1:0]   exp_q[$];
  logic [2*DW-1:0] m_buf[$];
  bit              m_cap = 1'b0;
  int              m_len = 0;
  int              held = 0;       // completed frames not yet fully replayed
  bit              exp_err_now = 1'b0;
  bit              exp_drop_now = 1'b0;
  int              xfer_cnt = 0;
  int              ready_mode = 1; // 0 low, 1 high, 2 random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

`ifdef FRAME_SINK_BITREV_EN
  function automatic int brev(input int k, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++)
      if ((k >> i) & 1) r = r | (1 << (lg - 1 - i));
    return r;
  endfunction
`endif

  // ---------------- reference model (frame level) ----------------
  always @(posedge clk) begin
    exp_err_now  = 1'b0;
    exp_drop_now = 1'b0;
    if (rst) begin
      m_cap = 1'b0;
      held  = 0;
      exp_q.delete();
      m_buf.delete();
    end else if (valid_in) begin
      if (sop_in && (m_cap || held < 2)) begin
        exp_err_now = m_cap;
        m_cap = 1'b1;
        m_len = 64 << np;
        m_buf.delete();
        m_buf.push_back({x_re, x_im});
      end else if (sop_in) begin
        exp_drop_now = 1'b1;
      end else if (m_cap) begin
        m_buf.push_back({x_re, x_im});
        if (m_buf.size() == m_len) begin
          for (int k = 0; k < m_len; k++) begin
            int a;
`ifdef FRAME_SINK_BITREV_EN
            a = brev(k, $clog2(m_len));
`else
            a = k;
`endif
            exp_q.push_back({k == 0, k == m_len - 1, AW'(k), m_buf[a]});
          end
          held++;
          m_cap = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [EW-1:0] mon_e;
  logic [EW-1:0] stall_bus;
  bit            stall_v = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      check("err_short", 64'(err_short), 64'(exp_err_now));
      check("drop", 64'(drop), 64'(exp_drop_now));
      if (stall_v)
        check("stable", 64'({out_sop, out_eop, out_idx, out_re, out_im}), 64'(stall_bus));
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 64'(out_idx), 64'(0));
            n_err++;
            $display("FAIL extra_sample: got idx %0d with empty queue", out_idx);
          end else begin
            mon_e = exp_q.pop_front();
            check("sample", 64'({out_sop, out_eop, out_idx, out_re, out_im}), 64'(mon_e));
            xfer_cnt++;
            if (mon_e[EW-2]) held--;
          end
        end
        stall_v   = !out_ready;
        stall_bus = {out_sop, out_eop, out_idx, out_re, out_im};
      end else begin
        stall_v = 1'b0;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_beat(input logic s, input logic [1:0] n,
                            input logic [DW-1:0] re, input logic [DW-1:0] im);
    valid_in = 1'b1;
    sop_in   = s;
    np       = n;
    x_re     = re;
    x_im     = im;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sop_in   = 1'b0;
  endtask

  // np is randomised on non-sop beats: only the sop beat may matter
  task automatic send_frame(input logic [1:0] n, input int beats,
                            input bit gaps, input bit ramp);
    for (int i = 0; i < beats; i++) begin
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      if (ramp) begin
        re = DW'(i);
        im = ~DW'(i);
      end else begin
        re = DW'($urandom);
        im = DW'($urandom);
      end
      drive_beat(i == 0, (i == 0) ? n : 2'($urandom_range(0, 3)), re, im);
      if (gaps) idle(1);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int t = 0;
    while ((exp_q.size() != 0 || held != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_drain_left"}, 64'(exp_q.size()), 64'(0));
    @(negedge clk);
    @(negedge clk);
    check({tag, "_idle_valid"}, 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic expect_stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 64'(out_valid), 64'(1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_sop"},   64'(out_sop), 64'(0));
    check({tag, "_eop"},   64'(out_eop), 64'(0));
    check({tag, "_re"},    64'(out_re), 64'(0));
    check({tag, "_im"},    64'(out_im), 64'(0));
    check({tag, "_idx"},   64'(out_idx), 64'(0));
    check({tag, "_err"},   64'(err_short), 64'(0));
    check({tag, "_drop"},  64'(drop), 64'(0));
    check({tag, "_state"}, 64'(wr_state_dbg), 64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int t;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // 1: np=0 ramp, latency and contiguity
    send_frame(2'd0, 64, 1'b0, 1'b1);
    @(negedge clk);
    check("t1_lat0", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("t1_lat1", 64'(out_valid), 64'(0));
    expect_stream("t1_stream", 64);
    @(negedge clk);
    check("t1_after", 64'(out_valid), 64'(0));
    wait_drain("t1", 200);

    // 2: np=3 with valid_in every other cycle
    send_frame(2'd3, 512, 1'b1, 1'b0);
    wait_drain("t2", 1500);

    // 3: np=1 short frame interrupted at beat 40
    send_frame(2'd1, 40, 1'b0, 1'b0);
    send_frame(2'd1, 128, 1'b0, 1'b0);
    wait_drain("t3", 400);

    // 4: stalled output, three back-to-back frames, third dropped
    ready_mode = 0;
    idle(2);
    send_frame(2'd0, 64, 1'b0, 1'b0);
    send_frame(2'd0, 64, 1'b0, 1'b0);
    send_frame(2'd0, 64, 1'b0, 1'b0);
    idle(4);
    @(negedge clk);
    check("t4_hold_valid", 64'(out_valid), 64'(1));
    @(posedge clk);
    #1;
    ready_mode = 1;
    out_ready  = 1'b1;
    expect_stream("t4_stream", 128);
    wait_drain("t4", 300);

    // 5: random out_ready, np=2
    ready_mode = 2;
    send_frame(2'd2, 256, 1'b0, 1'b0);
    wait_drain("t5", 3000);
    ready_mode = 1;
    idle(2);

    // 6: reset in the middle of replay, then a clean frame
    base = xfer_cnt;
    send_frame(2'd1, 128, 1'b0, 1'b0);
    t = 0;
    while (xfer_cnt - base < 100 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("t6_reached_100", 64'(xfer_cnt - base >= 100), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("t6_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    send_frame(2'd0, 64, 1'b0, 1'b1);
    wait_drain("t6_after", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
